logistic_arbiter: RTL
=====================

Name: logistic_arbiter

Overview:
Shares one logistic activation unit among N neuron requesters. Each transaction is argument -> activation, plus feedback -> delta when training, and the grant is held for the whole transaction. Round-robin arbitration is used between requesters, and the block latches the train mode per transaction. It sits between the neuron array and the single activation unit instance.

Parameters:
N, 4, number of requesters (N >= 2)
IW, $clog2(N), grant index width (derived, not overridable)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
train  in  1  global training mode, sampled at grant
argument_valid  in  N  per-requester argument valid
argument_data  in  N x 16  per-requester signed Q8.8 argument
argument_ready  out  N  per-requester argument ready
activation_valid  out  N  per-requester activation valid
activation_data  out  8  activation, broadcast to all requesters
activation_ready  in  N  per-requester activation ready
feedback_valid  in  N  per-requester feedback valid
feedback_data  in  N x 16  per-requester signed feedback
feedback_ready  out  N  per-requester feedback ready
delta_valid  out  N  per-requester delta valid
delta_data  out  16  delta, broadcast to all requesters
delta_ready  in  N  per-requester delta ready
unit_train  out  1  latched mode driven to the shared unit
unit_argument_valid/data/ready  out/out/in  1/16/1  unit argument channel
unit_activation_valid/data/ready  in/in/out  1/8/1  unit activation channel
unit_feedback_valid/data/ready  out/out/in  1/16/1  unit feedback channel
unit_delta_valid/data/ready  in/in/out  1/16/1  unit delta channel
grant  out  N  one-hot owner of the current transaction (0 in IDLE)
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, ARG, ACT, FBK, DEL. Every handshake is valid & ready in the same cycle.
- IDLE:
  - If any argument_valid is high, register grant to the first requester at or after ptr (cyclic), latch train_q <= train, go to ARG.
  - Arbitration takes exactly 1 cycle. No ready is asserted in IDLE.
- ARG: unit_argument_valid = argument_valid[g], unit_argument_data = argument_data[g], argument_ready[g] = unit_argument_ready. Go to ACT on the unit handshake.
- ACT: activation_valid[g] = unit_activation_valid, unit_activation_ready = activation_ready[g]. On handshake go to FBK if train_q, else to IDLE.
- FBK: route feedback[g] to the unit the same way as ARG. Go to DEL on handshake.
- DEL: route unit delta to requester g the same way as ACT. Go to IDLE on handshake.
- On the transition into IDLE, ptr <= g+1, wrapping to 0 after N-1.
- All routing is combinational: no added latency beyond the 1-cycle grant. Non-granted requesters see ready=0 and valid=0.
- unit_* valid/ready outputs are 0 outside their own state.
- activation_data and delta_data are driven from the unit at all times. They are meaningful only with the matching valid.
- unit_train = train_q, held constant for the whole transaction. A change on train mid-transaction has no effect until the next grant.
- Requesters must not retract argument_valid before the handshake. If one does, the grant is still held and the arbiter waits in ARG.
- Simultaneous requests are resolved by round-robin from ptr, so there is no starvation: worst-case wait is N-1 transactions.
- Reset (asynchronous assert, synchronous deassert at the user):
  - state=IDLE, ptr=0, train_q=0, grant=0, busy=0.
  - All valid and ready outputs are 0 during and after reset.
  - A mid-transaction reset aborts the transaction. The shared unit shares the same reset.
- Never drive more than one grant bit. An illegal state asserts an error in simulation and returns to IDLE.

Decomposition:
- Package logistic_pkg:
  - widths: ARGUMENT_W=16, ACTIVATION_W=8, FEEDBACK_W=16, DELTA_W=16
  - state enum type arb_state_t with a NOENUM localparam fallback.
- One sub-module, rr_arbiter:
  - parameter N; inputs request[N] and ptr; output one-hot grant plus index.
  - Purely combinational, reusable elsewhere.

Test Plan:
- Inference, single requester: train=0, argument_valid[2] with 16'h0100, unit returns 8'hBB. Expect grant=4'b0100 one cycle later, then activation_valid[2]=1 and data 8'hBB. After the ready handshake, IDLE and ptr=3.
- Round-robin: all 4 requesters assert at once with ptr=0. Expect grant order 0,1,2,3,0, each a full transaction, and no overlap.
- Training: train=1 at grant, requester 1 feedback 16'hFF00, unit delta 16'hFFC0. Expect states ARG, ACT, FBK, DEL. Expect delta_valid[1] with 16'hFFC0 and feedback_ready seen only on index 1.
- Mode latch: train drops to 0 during ACT of a train=1 transaction. Expect FBK and DEL still executed and unit_train held at 1 until IDLE.
- Backpressure: hold activation_ready[0]=0 for 5 cycles. Expect unit_activation_ready=0 and state ACT held. Other requesters' argument_ready stay 0.
- Reset mid-DEL: assert reset low. Expect all valids, readies and grant at 0 immediately (asynchronous) and ptr=0. After release, a fresh request from requester 3 is granted normally.

Source files
------------

// File: rtl/logistic_pkg.sv
// Shared widths and FSM state type for the logistic activation arbiter.
package logistic_pkg;

   localparam int ARGUMENT_W   = 16;  // signed Q8.8 argument
   localparam int ACTIVATION_W = 8;   // activation result
   localparam int FEEDBACK_W   = 16;  // signed training feedback
   localparam int DELTA_W      = 16;  // delta returned when training

`ifndef NOENUM
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARG  = 3'd1,
      S_ACT  = 3'd2,
      S_FBK  = 3'd3,
      S_DEL  = 3'd4
   } arb_state_t;
`else
   // Fallback for flows that cannot carry enum types through their netlists.
   typedef logic [2:0] arb_state_t;
   localparam arb_state_t S_IDLE = 3'd0;
   localparam arb_state_t S_ARG  = 3'd1;
   localparam arb_state_t S_ACT  = 3'd2;
   localparam arb_state_t S_FBK  = 3'd3;
   localparam arb_state_t S_DEL  = 3'd4;
`endif

endpackage

// File: rtl/logistic_arbiter_if.sv
// Handshake bundles: neuron-array side (N requesters) and shared activation unit side.

// Requester side. master = neuron array, slave = arbiter.
interface logistic_req_if #(
   parameter int N = 4
);
   import logistic_pkg::*;

   logic [N-1:0]                    argument_valid;
   logic [N-1:0][ARGUMENT_W-1:0]    argument_data;
   logic [N-1:0]                    argument_ready;
   logic [N-1:0]                    activation_valid;
   logic [ACTIVATION_W-1:0]         activation_data;
   logic [N-1:0]                    activation_ready;
   logic [N-1:0]                    feedback_valid;
   logic [N-1:0][FEEDBACK_W-1:0]    feedback_data;
   logic [N-1:0]                    feedback_ready;
   logic [N-1:0]                    delta_valid;
   logic [DELTA_W-1:0]              delta_data;
   logic [N-1:0]                    delta_ready;

   modport master (
      output argument_valid, argument_data, activation_ready,
             feedback_valid, feedback_data, delta_ready,
      input  argument_ready, activation_valid, activation_data,
             feedback_ready, delta_valid, delta_data
   );

   modport slave (
      input  argument_valid, argument_data, activation_ready,
             feedback_valid, feedback_data, delta_ready,
      output argument_ready, activation_valid, activation_data,
             feedback_ready, delta_valid, delta_data
   );
endinterface

// Shared unit side. master = arbiter, slave = activation unit.
interface logistic_unit_if;
   import logistic_pkg::*;

   logic                    train;
   logic                    argument_valid;
   logic [ARGUMENT_W-1:0]   argument_data;
   logic                    argument_ready;
   logic                    activation_valid;
   logic [ACTIVATION_W-1:0] activation_data;
   logic                    activation_ready;
   logic                    feedback_valid;
   logic [FEEDBACK_W-1:0]   feedback_data;
   logic                    feedback_ready;
   logic                    delta_valid;
   logic [DELTA_W-1:0]      delta_data;
   logic                    delta_ready;

   modport master (
      output train, argument_valid, argument_data, activation_ready,
             feedback_valid, feedback_data, delta_ready,
      input  argument_ready, activation_valid, activation_data,
             feedback_ready, delta_valid, delta_data
   );

   modport slave (
      input  train, argument_valid, argument_data, activation_ready,
             feedback_valid, feedback_data, delta_ready,
      output argument_ready, activation_valid, activation_data,
             feedback_ready, delta_valid, delta_data
   );
endinterface

// File: rtl/logistic_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, cyclically.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  request,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] index,
   output logic          found
);

   logic [IW-1:0] cand;

   // Scan N positions starting at ptr; the first active request wins.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
      grant = '0;
      index = '0;
      found = 1'b0;
      cand  = '0;
      for (int off = 0; off < N; off++) begin
         cand = IW'((int'(ptr) + off) % N);
         if (!found && request[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            index       = cand;
         end
      end
   end

endmodule

// File: rtl/logistic_arbiter.sv
// Shares one logistic activation unit among N requesters; the grant is held for a
// whole argument->activation (and feedback->delta when training) transaction.
module logistic_arbiter
   import logistic_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            train,
   logistic_req_if.slave   req,
   logistic_unit_if.master unit,
   output logic [N-1:0]    grant,
   output logic            busy
);

   arb_state_t    state, state_nx;
   logic [IW-1:0] ptr;
   logic [IW-1:0] owner;
   logic [N-1:0]  grant_q;
   logic          train_q;
   logic          txn_done;

   logic [N-1:0]  arb_grant;
   logic [IW-1:0] arb_index;
   logic          arb_found;

   logic [N-1:0]            arg_ready, act_valid, fbk_ready, del_valid;
   logic                    u_arg_valid, u_act_ready, u_fbk_valid, u_del_ready;
   logic [ARGUMENT_W-1:0]   u_arg_data;
   logic [FEEDBACK_W-1:0]   u_fbk_data;

   rr_arbiter #(.N(N)) u_rr (
      .request (req.argument_valid),
      .ptr     (ptr),
      .grant   (arb_grant),
      .index   (arb_index),
      .found   (arb_found)
   );

   // Next state plus combinational routing between the owner and the unit.
   always_comb begin
      state_nx    = state;
      txn_done    = 1'b0;
      arg_ready   = '0;
      act_valid   = '0;
      fbk_ready   = '0;
      del_valid   = '0;
      u_arg_valid = 1'b0;
      u_act_ready = 1'b0;
      u_fbk_valid = 1'b0;
      u_del_ready = 1'b0;
      u_arg_data  = '0;
      u_fbk_data  = '0;
      case (state)
         S_IDLE: begin
            if (arb_found) state_nx = S_ARG;
         end
         S_ARG: begin
            u_arg_valid      = req.argument_valid[owner];
            u_arg_data       = req.argument_data[owner];
            arg_ready[owner] = unit.argument_ready;
            if (u_arg_valid && unit.argument_ready) state_nx = S_ACT;
         end
         S_ACT: begin
            act_valid[owner] = unit.activation_valid;
            u_act_ready      = req.activation_ready[owner];
            if (unit.activation_valid && u_act_ready) begin
               if (train_q) begin
                  state_nx = S_FBK;
               end else begin
                  state_nx = S_IDLE;
                  txn_done = 1'b1;
               end
            end
         end
         S_FBK: begin
            u_fbk_valid      = req.feedback_valid[owner];
            u_fbk_data       = req.feedback_data[owner];
            fbk_ready[owner] = unit.feedback_ready;
            if (u_fbk_valid && unit.feedback_ready) state_nx = S_DEL;
         end
         S_DEL: begin
            del_valid[owner] = unit.delta_valid;
            u_del_ready      = req.delta_ready[owner];
            if (unit.delta_valid && u_del_ready) begin
               state_nx = S_IDLE;
               txn_done = 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // State register; owner, grant and train mode are captured once per transaction.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
         state   <= S_IDLE;
         ptr     <= '0;
         owner   <= '0;
         grant_q <= '0;
         train_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && arb_found) begin
            grant_q <= arb_grant;
            owner   <= arb_index;
            train_q <= train;
         end else if (state != S_IDLE && state_nx == S_IDLE) begin
            grant_q <= '0;
            if (txn_done) ptr <= (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
         end
      end
   end

   // Simulation guard: flag encodings outside the state set and multi-hot grants.
   always_ff @(posedge clock) begin
      if (reset) begin
         assert (state inside {S_IDLE, S_ARG, S_ACT, S_FBK, S_DEL});
         assert ($onehot0(grant_q));
      end
   end

   assign grant = grant_q;
   assign busy  = (state != S_IDLE);

   assign req.argument_ready   = arg_ready;
   assign req.activation_valid = act_valid;
   assign req.activation_data  = unit.activation_data;
   assign req.feedback_ready   = fbk_ready;
   assign req.delta_valid      = del_valid;
   assign req.delta_data       = unit.delta_data;

   assign unit.train            = train_q;
   assign unit.argument_valid   = u_arg_valid;
   assign unit.argument_data    = u_arg_data;
   assign unit.activation_ready = u_act_ready;
   assign unit.feedback_valid   = u_fbk_valid;
   assign unit.feedback_data    = u_fbk_data;
   assign unit.delta_ready      = u_del_ready;

endmodule
